// File: rtl/player_ctrl_if.sv
// player_ctrl_if: codec-driver side of the playback controller.
// Carries the track index, volume word, play status, mode, error pulse
// and the load request/acknowledge handshake.
`timescale 1ns/1ps
interface player_ctrl_if #(
   parameter int SONG_W = 3,
   parameter int VOL_W  = 8
);
   logic [SONG_W-1:0]  o_song_select;
   logic [2*VOL_W-1:0] o_vol;
   logic               o_pause;
   logic               o_stopped;
   logic               o_load_req;
   logic [1:0]         o_mode;
   logic               o_err;
   logic               i_load_ack;

   // Controller side: drives status and the request, receives the acknowledge.
   modport master (
      output o_song_select, o_vol, o_pause, o_stopped, o_load_req, o_mode, o_err,
      input  i_load_ack
   );

   // Codec driver side.
   modport slave (
      input  o_song_select, o_vol, o_pause, o_stopped, o_load_req, o_mode, o_err,
      output i_load_ack
   );
endinterface

// File: rtl/player_ctrl.sv
// player_ctrl: turns single-cycle command pulses into the registered track
// index, codec volume word and play/pause/stop state, and runs the load
// request/acknowledge handshake towards the codec driver with a timeout.
// Optional shuffle play mode (LFSR track pick) is compiled in when the
// macro PLAYER_SHUFFLE_EN is defined; without it the mode cycles 0->1->2->0.
`timescale 1ns/1ps
module player_ctrl #(
   parameter int               SONG_NUM    = 8,
   parameter int               SONG_W      = 3,
   parameter int               VOL_W       = 8,
   parameter logic [VOL_W-1:0] VOL_INIT    = 8'h20,
   parameter logic [VOL_W-1:0] VOL_STEP    = 8'h10,
   parameter logic [VOL_W-1:0] VOL_ATT_MAX = 8'hFE,
   parameter int               ACK_TIMEOUT = 50000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_next,
   input  logic          i_pre,
   input  logic          i_vol_plus,
   input  logic          i_vol_dec,
   input  logic          i_pause_toggle,
   input  logic          i_mode_cycle,
   input  logic          i_finish,
   player_ctrl_if.master bus
);

   localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [SONG_W-1:0] IDX_LAST = SONG_W'(SONG_NUM - 1);

   localparam logic [1:0] MODE_SEQ  = 2'd0;
   localparam logic [1:0] MODE_RALL = 2'd1;
   localparam logic [1:0] MODE_RONE = 2'd2;
   localparam logic [1:0] MODE_SHUF = 2'd3;

   typedef enum logic [1:0] {
      STOPPED = 2'd0,
      PLAY    = 2'd1,
      PAUSED  = 2'd2,
      LOAD    = 2'd3
   } state_t;

   state_t            state_reg,   state_next;
   logic [SONG_W-1:0] song_reg,    song_next;
   logic [VOL_W-1:0]  att_reg,     att_next;
   logic [1:0]        mode_reg,    mode_next;
   logic [CNT_W-1:0]  cnt_reg,     cnt_next;
   logic              err_reg,     err_next;
   logic              pause_reg,   pause_next;
   logic              stopped_reg, stopped_next;
   logic              req_reg,     req_next;

   logic              nav_next, nav_pre;
   logic [SONG_W-1:0] idx_inc, idx_dec, idx_fwd;
   logic              shuffle_on;
   logic [SONG_W-1:0] shuf_idx;
   logic [VOL_W:0]    att_sub, att_add;

   // next and pre in the same cycle cancel each other out
   assign nav_next = i_next & ~i_pre;
   assign nav_pre  = i_pre  & ~i_next;

   assign idx_inc = (song_reg == IDX_LAST) ? '0 : song_reg + 1'b1;
   assign idx_dec = (song_reg == '0) ? IDX_LAST : song_reg - 1'b1;

`ifdef PLAYER_SHUFFLE_EN
   localparam logic [SONG_W:0] NUM_EXT = (SONG_W+1)'(SONG_NUM);

   logic [15:0]       lfsr_reg;
   logic [15:0]       lfsr_next;
   logic [SONG_W-1:0] shuf_raw;

   // Free-running 16-bit maximal LFSR (taps 16,14,13,11)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_reg <= 16'hACE1;
      else        lfsr_reg <= lfsr_next;
   end

   // Random pick folded into range; never repeat the current track
   always_comb begin
      lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      shuf_raw  = SONG_W'({1'b0, lfsr_reg[SONG_W-1:0]} % NUM_EXT);
      shuf_idx  = (shuf_raw == song_reg) ? idx_inc : shuf_raw;
   end

   assign shuffle_on = (mode_reg == MODE_SHUF);
`else
   assign shuffle_on = 1'b0;
   assign shuf_idx   = idx_inc;
`endif

   // Forward step used by next (and by finish while shuffling)
   assign idx_fwd = shuffle_on ? shuf_idx : idx_inc;

   // Volume arithmetic one bit wider so borrow/overflow is visible
   always_comb begin
      att_sub  = {1'b0, att_reg} - {1'b0, VOL_STEP};
      att_add  = {1'b0, att_reg} + {1'b0, VOL_STEP};
      att_next = att_reg;
      if (i_vol_plus && !i_vol_dec) begin
         att_next = att_sub[VOL_W] ? '0 : att_sub[VOL_W-1:0];
      end else if (i_vol_dec && !i_vol_plus) begin
         att_next = (att_add > {1'b0, VOL_ATT_MAX}) ? VOL_ATT_MAX : att_add[VOL_W-1:0];
      end
   end

   // Play-mode rotation; shuffle is only reachable when compiled in
   always_comb begin
      mode_next = mode_reg;
      if (i_mode_cycle) begin
`ifdef PLAYER_SHUFFLE_EN
         mode_next = mode_reg + 2'd1;
`else
         mode_next = (mode_reg == MODE_RONE) ? MODE_SEQ : mode_reg + 2'd1;
`endif
      end
   end

   // Playback FSM next-state, track index and load timeout
   always_comb begin
      state_next = state_reg;
      song_next  = song_reg;
      cnt_next   = '0;
      err_next   = 1'b0;
      case (state_reg)
         STOPPED: begin
            if (nav_next) begin
               song_next  = idx_fwd;
               state_next = LOAD;
            end else if (nav_pre) begin
               song_next  = idx_dec;
               state_next = LOAD;
            end else if (i_pause_toggle) begin
               song_next  = '0;
               state_next = LOAD;
            end
         end
         PLAY: begin
            if (nav_next) begin
               song_next  = idx_fwd;
               state_next = LOAD;
            end else if (nav_pre) begin
               song_next  = idx_dec;
               state_next = LOAD;
            end else if (i_pause_toggle) begin
               state_next = PAUSED;
            end else if (i_finish) begin
               case (mode_reg)
                  MODE_SEQ: begin
                     if (song_reg == IDX_LAST) begin
                        state_next = STOPPED;
                     end else begin
                        song_next  = idx_inc;
                        state_next = LOAD;
                     end
                  end
                  MODE_RALL: begin
                     song_next  = idx_inc;
                     state_next = LOAD;
                  end
                  MODE_RONE: begin
                     state_next = LOAD;
                  end
                  default: begin
                     song_next  = shuf_idx;
                     state_next = LOAD;
                  end
               endcase
            end
         end
         PAUSED: begin
            if (nav_next) begin
               song_next  = idx_fwd;
               state_next = LOAD;
            end else if (nav_pre) begin
               song_next  = idx_dec;
               state_next = LOAD;
            end else if (i_pause_toggle) begin
               state_next = PLAY;
            end
         end
         LOAD: begin
            // Track commands are dropped while the driver is loading
            if (bus.i_load_ack) begin
               state_next = PLAY;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = PLAY;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = STOPPED;
      endcase
   end

   // Status flags registered from the next state so they line up with it
   always_comb begin
      pause_next   = (state_next == STOPPED) || (state_next == PAUSED);
      stopped_next = (state_next == STOPPED);
      req_next     = (state_next == LOAD);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= STOPPED;
         song_reg    <= '0;
         att_reg     <= VOL_INIT;
         mode_reg    <= MODE_SEQ;
         cnt_reg     <= '0;
         err_reg     <= 1'b0;
         pause_reg   <= 1'b1;
         stopped_reg <= 1'b1;
         req_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         song_reg    <= song_next;
         att_reg     <= att_next;
         mode_reg    <= mode_next;
         cnt_reg     <= cnt_next;
         err_reg     <= err_next;
         pause_reg   <= pause_next;
         stopped_reg <= stopped_next;
         req_reg     <= req_next;
      end
   end

   // Same attenuation on both codec channels
   for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign bus.o_vol[gi*VOL_W +: VOL_W] = att_reg;
   end

   assign bus.o_song_select = song_reg;
   assign bus.o_pause       = pause_reg;
   assign bus.o_stopped     = stopped_reg;
   assign bus.o_load_req    = req_reg;
   assign bus.o_mode        = mode_reg;
   assign bus.o_err         = err_reg;

endmodule
